// File: rtl/pingpong_drain.sv
// rtl/pingpong_drain.sv - two-bank ping-pong buffer: fill one bank while the other drains
module pingpong_drain #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             wr_valid,
  input  logic [WIDTH-1:0] wr_data,
  output logic             wr_ready,
  output logic             rd_valid,
  output logic [WIDTH-1:0] rd_data,
  input  logic             rd_ready,
  output logic             rd_last,
  output logic [1:0]       bank_full
);

  localparam int IW = $clog2(DEPTH);
  localparam logic [IW-1:0] LAST_IDX = IW'(DEPTH - 1);

  logic [WIDTH-1:0] mem [2][DEPTH];
  logic [1:0]       full;
  logic             wb;
  logic             rb;
  logic [IW-1:0]    wi;
  logic [IW-1:0]    ri;

  logic wr_fire;
  logic rd_fire;
  logic wr_last;

  // Outputs decode registered state only; a release never bypasses into wr_ready.
  assign wr_ready  = !full[wb];
  assign rd_valid  = full[rb];
  assign rd_data   = mem[rb][ri];
  assign rd_last   = rd_valid && (ri == LAST_IDX);
  assign bank_full = full;

  assign wr_fire = wr_valid && wr_ready;
  assign rd_fire = rd_valid && rd_ready;
  assign wr_last = (wi == LAST_IDX);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      full <= 2'b00;
      wb   <= 1'b0;
      wi   <= '0;
      rb   <= 1'b0;
      ri   <= '0;
      for (int b = 0; b < 2; b++) begin
        for (int i = 0; i < DEPTH; i++) begin
          mem[b][i] <= '0;
        end
      end
    end else begin
      // The write bank is never full and the read bank always is, so the
      // two updates below always touch different full bits.
      if (wr_fire) begin
        mem[wb][wi] <= wr_data;
        if (wr_last) begin
          full[wb] <= 1'b1;
          wb       <= ~wb;
          wi       <= '0;
        end else begin
          wi <= wi + 1'b1;
        end
      end
      if (rd_fire) begin
        if (rd_last) begin
          full[rb] <= 1'b0;
          rb       <= ~rb;
          ri       <= '0;
        end else begin
          ri <= ri + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_pingpong_drain.sv
// tb/tb_pingpong_drain.sv - directed self-checking bench for pingpong_drain
module tb_pingpong_drain;

  logic       clk;
  logic       reset_n;
  logic       wr_valid;
  logic [7:0] wr_data;
  logic       wr_ready;
  logic       rd_valid;
  logic [7:0] rd_data;
  logic       rd_ready;
  logic       rd_last;
  logic [1:0] bank_full;

  int n_vec;
  int n_err;

  pingpong_drain #(.WIDTH(8), .DEPTH(4)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .wr_valid (wr_valid),
    .wr_data  (wr_data),
    .wr_ready (wr_ready),
    .rd_valid (rd_valid),
    .rd_data  (rd_data),
    .rd_ready (rd_ready),
    .rd_last  (rd_last),
    .bank_full(bank_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check_vec({tag, "_wr_ready"}, 32'(wr_ready), 32'd1);
    check_vec({tag, "_rd_valid"}, 32'(rd_valid), 32'd0);
    check_vec({tag, "_rd_last"}, 32'(rd_last), 32'd0);
    check_vec({tag, "_rd_data"}, 32'(rd_data), 32'd0);
    check_vec({tag, "_bank_full"}, 32'(bank_full), 32'd0);
  endtask

  task automatic do_reset();
    reset_n  = 1'b0;
    wr_valid = 1'b0;
    wr_data  = 8'h00;
    rd_ready = 1'b0;
    #1;
    check_idle("in_reset");
    step();
    reset_n = 1'b1;
  endtask

  task automatic write_word(input logic [7:0] d);
    wr_valid = 1'b1;
    wr_data  = d;
    step();
    wr_valid = 1'b0;
  endtask

  initial begin
    int n_wr;
    int n_rd;
    int gaps;
    bit seen;
    n_vec = 0;
    n_err = 0;

    // Reset values at time 0
    do_reset();
    check_idle("after_reset");

    // Single bank fill then drain; first write lands on first edge after reset
    for (int k = 0; k < 4; k++) write_word(8'(8'h11 * (k + 1)));
    check_vec("t1_bank_full", 32'(bank_full), 32'h1);
    check_vec("t1_rd_valid", 32'(rd_valid), 32'd1);
    check_vec("t1_rd_data", 32'(rd_data), 32'h11);
    check_vec("t1_rd_last", 32'(rd_last), 32'd0);
    rd_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check_vec("t1_drain_data", 32'(rd_data), 32'(8'h11 * (k + 1)));
      check_vec("t1_drain_last", 32'(rd_last), 32'(k == 3));
      step();
    end
    rd_ready = 1'b0;
    check_vec("t1_empty_full", 32'(bank_full), 32'h0);
    check_vec("t1_empty_valid", 32'(rd_valid), 32'd0);

    // Backpressure: both banks full, 9th word refused
    do_reset();
    for (int k = 0; k < 8; k++) write_word(8'(k + 1));
    check_vec("t2_bank_full", 32'(bank_full), 32'h3);
    check_vec("t2_wr_ready", 32'(wr_ready), 32'd0);
    write_word(8'h09);
    check_vec("t2_full_after9", 32'(bank_full), 32'h3);
    check_vec("t2_ready_after9", 32'(wr_ready), 32'd0);
    rd_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      check_vec("t2_drain_data", 32'(rd_data), 32'(k + 1));
      check_vec("t2_drain_last", 32'(rd_last), 32'((k % 4) == 3));
      check_vec("t2_wr_ready", 32'(wr_ready), 32'(k >= 4));
      step();
    end
    rd_ready = 1'b0;
    check_vec("t2_empty_valid", 32'(rd_valid), 32'd0);
    check_vec("t2_empty_full", 32'(bank_full), 32'h0);

    // Release of A coincides with B's last write
    do_reset();
    for (int k = 0; k < 4; k++) write_word(8'(k + 1));
    for (int k = 0; k < 4; k++) begin
      wr_valid = 1'b1;
      wr_data  = 8'(k + 5);
      rd_ready = 1'b1;
      check_vec("t3_rd_data", 32'(rd_data), 32'(k + 1));
      step();
    end
    wr_valid = 1'b0;
    rd_ready = 1'b0;
    check_vec("t3_bank_full", 32'(bank_full), 32'h2);
    check_vec("t3_rd_data_b", 32'(rd_data), 32'h05);
    check_vec("t3_rd_valid", 32'(rd_valid), 32'd1);
    check_vec("t3_wr_ready", 32'(wr_ready), 32'd1);

    // Streaming 64 words
    do_reset();
    n_wr = 0;
    n_rd = 0;
    gaps = 0;
    seen = 1'b0;
    for (int cyc = 0; cyc < 300 && n_rd < 64; cyc++) begin
      wr_valid = (n_wr < 64);
      wr_data  = 8'(n_wr + 16);
      rd_ready = 1'b1;
      if (rd_valid) begin
        check_vec("t4_stream_data", 32'(rd_data), 32'(8'(n_rd + 16)));
        n_rd++;
        seen = 1'b1;
      end
      if (wr_valid && !wr_ready && seen) gaps++;
      if (wr_valid && wr_ready) n_wr++;
      step();
    end
    wr_valid = 1'b0;
    rd_ready = 1'b0;
    check_vec("t4_words_read", 32'(n_rd), 32'd64);
    check_vec("t4_ready_gaps", 32'(gaps), 32'd0);
    check_vec("t4_end_full", 32'(bank_full), 32'h0);

    // Reset mid-operation: A one word into draining, B two words in
    do_reset();
    for (int k = 0; k < 4; k++) write_word(8'(k + 1));
    wr_valid = 1'b1;
    wr_data  = 8'h05;
    rd_ready = 1'b1;
    step();
    wr_data  = 8'h06;
    rd_ready = 1'b0;
    step();
    wr_valid = 1'b0;
    check_vec("t5_pre_rd_data", 32'(rd_data), 32'h02);
    reset_n = 1'b0;
    #1;
    check_idle("t5_async");
    step();
    reset_n = 1'b1;
    for (int k = 0; k < 4; k++) write_word(8'(8'hA0 + k));
    check_vec("t5_bank_full", 32'(bank_full), 32'h1);
    rd_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check_vec("t5_drain_data", 32'(rd_data), 32'(8'hA0 + k));
      check_vec("t5_drain_last", 32'(rd_last), 32'(k == 3));
      step();
    end
    rd_ready = 1'b0;
    check_vec("t5_empty_full", 32'(bank_full), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pingpong_drain.md
PINGPONG_DRAIN -- requirements
Module: pingpong_drain

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data word width in bits.
REQ-002 SHALL have parameter DEPTH, default 4, words per bank; a power of two, at least 2.
REQ-003 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-004 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port wr_valid  input  1  write word offered.
REQ-006 SHALL have port wr_data  input  WIDTH  write word.
REQ-007 SHALL have port wr_ready  output  1  write word can be accepted this cycle.
REQ-008 SHALL have port rd_valid  output  1  read word available.
REQ-009 SHALL have port rd_data  output  WIDTH  read word.
REQ-010 SHALL have port rd_ready  input  1  consumer accepts rd_data this cycle.
REQ-011 SHALL have port rd_last  output  1  rd_data is the final word of the current bank.
REQ-012 SHALL have port bank_full  output  2  per-bank full flag; bit 0 = bank A, bit 1 = bank B.

Function
REQ-013 SHALL hold two banks (A, B) of DEPTH x WIDTH flops, with a full flag per bank.
REQ-014 SHALL keep write state (bank select wb, index wi) and read state (bank select rb, index ri); wi and ri are clog2(DEPTH) bits wide.
REQ-015 SHALL drive wr_ready = !full[wb], decoded from registered state only; no same-cycle bypass from read-side release.
REQ-016 SHALL store wr_data into bank[wb][wi] and increment wi on a write handshake (wr_valid && wr_ready).
REQ-017 SHALL, on a write handshake with wi == DEPTH-1, set full[wb], toggle wb and wrap wi to 0.
REQ-018 SHALL drive rd_valid = full[rb] and rd_data = bank[rb][ri], combinational from registers.
REQ-019 SHALL drive rd_last = rd_valid && (ri == DEPTH-1).
REQ-020 SHALL increment ri on a read handshake (rd_valid && rd_ready).
REQ-021 SHALL, on a read handshake with rd_last high, clear full[rb], toggle rb and wrap ri to 0.
REQ-022 SHALL hold rd_data and rd_last stable while rd_valid is high and rd_ready is low.
REQ-023 SHALL drain banks strictly in fill order: A, B, A, B, ...
REQ-024 SHALL assert rd_valid for the first word of a bank on the cycle after the handshake that writes that bank's last word.
REQ-025 SHALL process a write-bank completion and a read-bank release in the same cycle independently, with both taking effect.
REQ-026 SHALL, when both banks are full, hold wr_ready low; it rises the cycle after the read-side release of bank wb.
REQ-027 SHALL, when both banks are empty, hold rd_valid low and leave read state unchanged regardless of rd_ready.
REQ-028 SHALL never modify a bank while its full flag is set.
REQ-029 SHALL sustain one write and one read per cycle when the reader keeps pace (steady-state ping-pong), with no bubbles.

Reset
REQ-030 SHALL, on reset_n low, immediately clear full, wb, wi, rb, ri and all bank contents to 0.
REQ-031 SHALL drive outputs during and after reset as: wr_ready=1, rd_valid=0, rd_last=0, rd_data=0, bank_full=2'b00.
REQ-032 SHALL discard any partially written or partially read bank on reset asserted mid-operation.
REQ-033 SHALL accept a write on the first rising edge after reset_n deasserts.

Verification
REQ-034 SHALL cover single bank, WIDTH=8, DEPTH=4: write 0x11,0x22,0x33,0x44 with rd_ready=0 -> bank_full=01 next cycle, rd_valid=1, rd_data=0x11; then rd_ready=1 -> 0x11..0x44 over 4 cycles, rd_last only with 0x44, then bank_full=00.
REQ-035 SHALL cover backpressure: write 8 words 0x01..0x08 with rd_ready=0 -> bank_full=11, wr_ready=0, a 9th word offered is not stored; drain -> 0x01..0x08 in order; wr_ready=1 the cycle after 0x04 is consumed.
REQ-036 SHALL cover simultaneous events: release bank A (0x04 consumed) in the same cycle bank B's last word 0x08 is written -> next cycle bank_full=10, rd_data=0x05, wr_ready=1.
REQ-037 SHALL cover streaming: continuous wr_valid=1, rd_ready=1, incrementing data -> output stream identical to input, no lost or duplicated words over 64 words, no wr_ready gap once the first bank drains.
REQ-038 SHALL cover reset mid-operation: assert reset_n=0 after 2 words of bank B while bank A is 1 word into draining -> immediately bank_full=00, rd_valid=0, wr_ready=1; after release, write 0xA0..0xA3 -> drains 0xA0..0xA3 from bank A.
